// File: rtl/rx_huge_page_allocator_pkg.sv
// rtl/rx_huge_page_allocator_pkg.sv - shared constants, FSM encoding and TLP fields for the RX huge-page path
package rx_huge_page_allocator_pkg;

  localparam int PAGE_QW        = 262144;
  localparam int MAX_PAYLOAD_QW = 16;
  localparam int OFF_W          = 19;
  localparam int FRAME_LEN_W    = 11;
  localparam int CHUNK_LEN_W    = 5;
  localparam int ADDR_W         = 64;

  typedef enum logic [1:0] {
    WAIT_PAGE = 2'd0,
    READY     = 2'd1,
    BURST     = 2'd2,
    CLOSE     = 2'd3
  } state_t;

  // TLP header fields shared by the RX and TX engines
  localparam logic [1:0] TLP_FMT_3DW_NODATA = 2'b00;
  localparam logic [1:0] TLP_FMT_4DW_NODATA = 2'b01;
  localparam logic [1:0] TLP_FMT_3DW_DATA   = 2'b10;
  localparam logic [1:0] TLP_FMT_4DW_DATA   = 2'b11;
  localparam logic [4:0] TLP_TYPE_MEM       = 5'b00000;
  localparam logic [4:0] TLP_TYPE_CPL       = 5'b01010;

  function automatic logic [OFF_W-1:0] round_up(input logic [OFF_W-1:0] len,
                                                input logic [OFF_W-1:0] unit);
    return ((len + unit - 19'd1) / unit) * unit;
  endfunction

endpackage

// File: rtl/rx_huge_page_allocator_if.sv
// rtl/rx_huge_page_allocator_if.sv - frame request and write command handshakes of the huge-page allocator
interface rx_huge_page_allocator_if;
  import rx_huge_page_allocator_pkg::*;

  logic                   frame_req_valid;
  logic [FRAME_LEN_W-1:0] frame_req_len_qw;
  logic                   frame_req_ready;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_W-1:0]      wr_addr;
  logic [CHUNK_LEN_W-1:0] wr_len_qw;
  logic                   wr_last;

  modport master (
    input  frame_req_valid, frame_req_len_qw, wr_ready,
    output frame_req_ready, wr_valid, wr_addr, wr_len_qw, wr_last
  );

  modport slave (
    output frame_req_valid, frame_req_len_qw, wr_ready,
    input  frame_req_ready, wr_valid, wr_addr, wr_len_qw, wr_last
  );

endinterface

// File: rtl/rx_huge_page_allocator.sv
// rtl/rx_huge_page_allocator.sv - places received frames into two ping-pong huge pages as payload-sized write chunks
module rx_huge_page_allocator #(
  parameter int PAGE_QW        = rx_huge_page_allocator_pkg::PAGE_QW,
  parameter int MAX_PAYLOAD_QW = rx_huge_page_allocator_pkg::MAX_PAYLOAD_QW
) (
  input  logic                     trn_clk,
  input  logic                     reset,
  input  logic [63:0]              huge_page_addr_1,
  input  logic [63:0]              huge_page_addr_2,
  input  logic                     huge_page_status_1,
  input  logic                     huge_page_status_2,
  output logic                     huge_page_free_1,
  output logic                     huge_page_free_2,
  rx_huge_page_allocator_if.master bus
);
  import rx_huge_page_allocator_pkg::*;

  localparam logic [OFF_W-1:0]       PAGE_L    = OFF_W'(PAGE_QW);
  localparam logic [OFF_W-1:0]       CHUNK_L   = OFF_W'(MAX_PAYLOAD_QW);
  localparam logic [FRAME_LEN_W-1:0] CHUNK_REM = FRAME_LEN_W'(MAX_PAYLOAD_QW);

  state_t                 state_q, state_d;
  logic                   cur_page_q, cur_page_d;
  logic [OFF_W-1:0]       offset_q, offset_d;
  logic [FRAME_LEN_W-1:0] remaining_q, remaining_d;
  logic [63:0]            page_base_q, page_base_d;
  logic                   wr_valid_q, wr_valid_d;
  logic                   free_1_q, free_1_d;
  logic                   free_2_q, free_2_d;

  logic                   page_status;
  logic [63:0]            page_addr;
  logic [OFF_W-1:0]       rounded_len;
  logic                   fits;
  logic                   chunk_last;
  logic [CHUNK_LEN_W-1:0] chunk_len;
  logic                   wr_fire;
  logic [OFF_W-1:0]       next_offset;

  assign page_status = cur_page_q ? huge_page_status_2 : huge_page_status_1;
  assign page_addr   = cur_page_q ? huge_page_addr_2 : huge_page_addr_1;
  assign rounded_len = round_up(OFF_W'(bus.frame_req_len_qw), CHUNK_L);
  assign fits        = (offset_q + rounded_len) <= PAGE_L;
  assign chunk_last  = remaining_q <= CHUNK_REM;
  assign chunk_len   = chunk_last ? CHUNK_LEN_W'(remaining_q) : CHUNK_LEN_W'(MAX_PAYLOAD_QW);
  assign wr_fire     = wr_valid_q && bus.wr_ready;
  // Offset always steps a full payload so every frame starts payload-aligned
  assign next_offset = offset_q + CHUNK_L;

  assign bus.frame_req_ready = (state_q == READY) && bus.frame_req_valid && fits;
  assign bus.wr_valid        = wr_valid_q;
  assign bus.wr_addr         = wr_valid_q ? page_base_q + 64'({offset_q, 3'b000}) : '0;
  assign bus.wr_len_qw       = wr_valid_q ? chunk_len : '0;
  assign bus.wr_last         = wr_valid_q && chunk_last;
  assign huge_page_free_1    = free_1_q;
  assign huge_page_free_2    = free_2_q;

  always_comb begin
    state_d     = state_q;
    cur_page_d  = cur_page_q;
    offset_d    = offset_q;
    remaining_d = remaining_q;
    page_base_d = page_base_q;
    wr_valid_d  = wr_valid_q;
    case (state_q)
      WAIT_PAGE: begin
        if (page_status) begin
          state_d     = READY;
          page_base_d = page_addr;
        end
      end
      READY: begin
        // A frame that does not fit stays pending and is retried on the next page
        if (bus.frame_req_ready) begin
          if (bus.frame_req_len_qw != '0) begin
            remaining_d = bus.frame_req_len_qw;
            wr_valid_d  = 1'b1;
            state_d     = BURST;
          end
        end else if (!page_status) begin
          state_d = WAIT_PAGE;
        end else if (bus.frame_req_valid) begin
          state_d = CLOSE;
        end
      end
      BURST: begin
        if (wr_fire) begin
          offset_d    = next_offset;
          remaining_d = remaining_q - FRAME_LEN_W'(chunk_len);
          if (chunk_last) begin
            wr_valid_d = 1'b0;
            state_d    = (next_offset == PAGE_L) ? CLOSE : READY;
          end
        end
      end
      CLOSE: begin
        offset_d    = '0;
        remaining_d = '0;
        cur_page_d  = ~cur_page_q;
        state_d     = WAIT_PAGE;
      end
      default: state_d = WAIT_PAGE;
    endcase
    free_1_d = (state_d == CLOSE) && !cur_page_d;
    free_2_d = (state_d == CLOSE) && cur_page_d;
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state_q     <= WAIT_PAGE;
      cur_page_q  <= 1'b0;
      offset_q    <= '0;
      remaining_q <= '0;
      page_base_q <= '0;
      wr_valid_q  <= 1'b0;
      free_1_q    <= 1'b0;
      free_2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_page_q  <= cur_page_d;
      offset_q    <= offset_d;
      remaining_q <= remaining_d;
      page_base_q <= page_base_d;
      wr_valid_q  <= wr_valid_d;
      free_1_q    <= free_1_d;
      free_2_q    <= free_2_d;
    end
  end

endmodule

// File: tb/tb_rx_huge_page_allocator.sv
// tb/tb_rx_huge_page_allocator.sv - scoreboard bench for rx_huge_page_allocator
module tb_rx_huge_page_allocator;

  localparam int PAGE = 4096;
  localparam int MAXP = 16;

  typedef struct {
    bit          is_free;
    int          page;
    logic [63:0] addr;
    int          len;
    bit          last;
  } ev_t;

  logic        trn_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [63:0] addr_1, addr_2;
  logic        status_1, status_2;
  logic        free_1, free_2;

  rx_huge_page_allocator_if bus();

  rx_huge_page_allocator #(.PAGE_QW(PAGE), .MAX_PAYLOAD_QW(MAXP)) dut (
    .trn_clk            (trn_clk),
    .reset              (reset),
    .huge_page_addr_1   (addr_1),
    .huge_page_addr_2   (addr_2),
    .huge_page_status_1 (status_1),
    .huge_page_status_2 (status_2),
    .huge_page_free_1   (free_1),
    .huge_page_free_2   (free_2),
    .bus                (bus)
  );

  always #5 trn_clk = ~trn_clk;

  int          n_vec = 0;
  int          n_mis = 0;
  ev_t         exp_q[$];
  int          hs_total = 0;
  int          stall_at = -1;
  int          ready_mode = 0;
  int          m_page, m_off;
  logic [63:0] m_base;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] page_addr(input int p);
    return (p == 0) ? addr_1 : addr_2;
  endfunction

  // Reference: pages fill in 16-qword slots; a frame that does not fit closes the page first
  task automatic m_close();
    ev_t e;
    e.is_free = 1'b1; e.page = m_page; e.addr = '0; e.len = 0; e.last = 1'b0;
    exp_q.push_back(e);
    m_page = 1 - m_page;
    m_off  = 0;
    m_base = page_addr(m_page);
  endtask

  task automatic m_issue(input int len);
    int  n;
    ev_t e;
    n = (len + MAXP - 1) / MAXP;
    if (m_off + n * MAXP > PAGE) m_close();
    for (int i = 0; i < n; i++) begin
      e.is_free = 1'b0;
      e.page    = m_page;
      e.addr    = m_base + 64'((m_off + i * MAXP) * 8);
      e.len     = (len - i * MAXP < MAXP) ? len - i * MAXP : MAXP;
      e.last    = (i == n - 1);
      exp_q.push_back(e);
    end
    m_off += n * MAXP;
    if (n > 0 && m_off == PAGE) m_close();
  endtask

  int stall_left = 0;
  int stall_done = -1;
  always @(posedge trn_clk) begin
    #1;
    if (stall_left > 0) begin
      bus.wr_ready = 1'b0;
      stall_left--;
    end else if (bus.wr_valid && stall_at >= 0 && hs_total == stall_at && stall_done != stall_at) begin
      stall_done   = stall_at;
      stall_left   = 4;
      bus.wr_ready = 1'b0;
    end else if (ready_mode == 0) begin
      bus.wr_ready = 1'b1;
    end else begin
      bus.wr_ready = ($urandom_range(0, 3) != 0);
    end
  end

  ev_t         mon_e;
  bit          stalled = 1'b0;
  logic [63:0] held_addr;
  logic [4:0]  held_len;
  logic        held_last;
  always @(negedge trn_clk) begin
    if (reset) begin
      exp_q.delete();
      stalled = 1'b0;
    end else begin
      if (free_1 || free_2) begin
        chk("free_exclusive", 64'(free_1 && free_2), 0);
        chk("free_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("free_kind", 64'(mon_e.is_free), 1);
          chk("free_page", free_2 ? 1 : 0, 64'(mon_e.page));
        end
      end
      if (bus.wr_valid) begin
        if (stalled) begin
          chk("stall_addr", bus.wr_addr, held_addr);
          chk("stall_len", 64'(bus.wr_len_qw), 64'(held_len));
          chk("stall_last", 64'(bus.wr_last), 64'(held_last));
        end
        if (bus.wr_ready) begin
          hs_total++;
          stalled = 1'b0;
          chk("wr_expected", 64'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("wr_kind", 64'(mon_e.is_free), 0);
            chk("wr_addr", bus.wr_addr, mon_e.addr);
            chk("wr_len", 64'(bus.wr_len_qw), 64'(mon_e.len));
            chk("wr_last", 64'(bus.wr_last), 64'(mon_e.last));
          end
        end else begin
          stalled   = 1'b1;
          held_addr = bus.wr_addr;
          held_len  = bus.wr_len_qw;
          held_last = bus.wr_last;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic present_frame(input int len);
    @(posedge trn_clk); #1;
    bus.frame_req_valid  = 1'b1;
    bus.frame_req_len_qw = 11'(len);
    m_issue(len);
  endtask

  task automatic wait_accept(input string name, input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge trn_clk);
      if (bus.frame_req_ready) done = 1'b1;
    end
    chk(name, 64'(done), 1);
    @(posedge trn_clk); #1;
    bus.frame_req_valid = 1'b0;
  endtask

  task automatic send_frame(input int len);
    present_frame(len);
    wait_accept("accept", 3000);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 5000 && !idle; i++) begin
      @(negedge trn_clk);
      if (exp_q.size() == 0 && !bus.wr_valid) idle = 1'b1;
    end
    chk("drain", 64'(idle), 1);
  endtask

  task automatic fill_to(input int target);
    int room, len;
    while (m_off < target) begin
      room = target - m_off;
      len  = $urandom_range(1, (room < 2047) ? room : 2047);
      send_frame(len);
    end
  endtask

  initial begin
    int len, h0;
    addr_1   = 64'h0000_0001_0000_0000;
    addr_2   = 64'h0000_0002_4000_0000;
    status_1 = 1'b0;
    status_2 = 1'b0;
    bus.frame_req_valid  = 1'b0;
    bus.frame_req_len_qw = '0;
    repeat (3) @(posedge trn_clk);
    @(negedge trn_clk);
    chk("rst_wr_valid", 64'(bus.wr_valid), 0);
    chk("rst_req_ready", 64'(bus.frame_req_ready), 0);
    chk("rst_free_1", 64'(free_1), 0);
    chk("rst_free_2", 64'(free_2), 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_len", 64'(bus.wr_len_qw), 0);
    @(posedge trn_clk); #1;
    reset    = 1'b0;
    status_1 = 1'b1;
    m_page = 0; m_off = 0; m_base = addr_1;
    repeat (3) @(posedge trn_clk); #1;
    addr_1 = 64'h0000_DEAD_0000_0000;

    send_frame(40);
    wait_idle();

    stall_at = hs_total + 1;
    send_frame(40);
    wait_idle();
    chk("stall_applied", 64'(stall_done), 64'(stall_at));

    present_frame(0);
    @(negedge trn_clk);
    chk("zero_accept", 64'(bus.frame_req_ready), 1);
    @(posedge trn_clk); #1;
    bus.frame_req_valid = 1'b0;
    repeat (6) begin
      @(negedge trn_clk);
      chk("zero_no_wr", 64'(bus.wr_valid), 0);
    end
    send_frame(5);
    wait_idle();

    ready_mode = 1;
    fill_to(PAGE - 16);
    wait_idle();
    present_frame(17);
    repeat (8) begin
      @(negedge trn_clk);
      chk("full_no_accept", 64'(bus.frame_req_ready), 0);
    end
    @(posedge trn_clk); #1;
    status_2 = 1'b1;
    wait_accept("full_accept", 3000);
    wait_idle();

    fill_to(PAGE - 16);
    wait_idle();
    send_frame(16);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 120);
      send_frame(len);
    end
    wait_idle();

    ready_mode = 0;
    h0 = hs_total;
    send_frame(40);
    for (int i = 0; i < 200 && hs_total < h0 + 1; i++) begin
      @(posedge trn_clk); #1;
    end
    chk("first_chunk_seen", 64'(hs_total >= h0 + 1), 1);
    reset    = 1'b1;
    status_1 = 1'b0;
    repeat (2) @(posedge trn_clk);
    #1;
    reset = 1'b0;
    m_page = 0; m_off = 0; m_base = addr_1;
    present_frame(8);
    repeat (5) begin
      @(negedge trn_clk);
      chk("post_rst_wr_valid", 64'(bus.wr_valid), 0);
      chk("post_rst_req_ready", 64'(bus.frame_req_ready), 0);
      chk("post_rst_free", 64'(free_1 || free_2), 0);
    end
    @(posedge trn_clk); #1;
    status_1 = 1'b1;
    wait_accept("post_rst_accept", 50);
    wait_idle();

    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/rx_huge_page_allocator.md
RX_HUGE_PAGE_ALLOCATOR -- requirements
Module: rx_huge_page_allocator

Interface
REQ-001 Parameters (name, default, meaning):
- PAGE_QW, 262144: huge page size in qwords (2 MiB).
- MAX_PAYLOAD_QW, 16: maximum write TLP payload in qwords (128 B).

REQ-002 Ports (name, direction, width, meaning):
- trn_clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high reset.
- huge_page_addr_1, in, 64: byte base address of page 1.
- huge_page_addr_2, in, 64: byte base address of page 2.
- huge_page_status_1, in, 1: page 1 is owned by hardware.
- huge_page_status_2, in, 1: page 2 is owned by hardware.
- huge_page_free_1, out, 1: one-cycle pulse that returns page 1 to the host.
- huge_page_free_2, out, 1: one-cycle pulse that returns page 2 to the host.
- frame_req_valid, in, 1: a received frame awaits placement.
- frame_req_len_qw, in, 11: frame length in qwords.
- frame_req_ready, out, 1: the frame request is accepted this cycle.
- wr_valid, out, 1: a write command is presented.
- wr_ready, in, 1: the TLP TX engine accepts the write command.
- wr_addr, out, 64: byte destination address of the chunk.
- wr_len_qw, out, 5: chunk length in qwords (1..MAX_PAYLOAD_QW).
- wr_last, out, 1: the chunk is the last one of its frame.

Function
REQ-003 The FSM SHALL have four states: WAIT_PAGE, READY, BURST, CLOSE.
REQ-004 WAIT_PAGE SHALL transition to READY in the cycle after the status input of the current page (cur_page, 0 = page 1) reads 1.
REQ-005 In READY, rounded_len SHALL equal frame_req_len_qw rounded up to a multiple of MAX_PAYLOAD_QW, and fits SHALL equal (offset + rounded_len <= PAGE_QW); all arithmetic SHALL be 19-bit unsigned.
REQ-006 frame_req_ready SHALL equal (state == READY) && frame_req_valid && fits; it is combinational.
REQ-007 In READY, when frame_req_valid && !fits, the block SHALL go to CLOSE and leave the request pending (not accept it).
REQ-008 On acceptance of a frame with len 0, the block SHALL issue no commands and stay in READY; offset SHALL be unchanged.
REQ-009 On acceptance of a frame with len > 0, the block SHALL latch the length and go to BURST, and wr_valid SHALL rise in the next cycle.
REQ-010 In BURST:
- wr_addr = page_base + (offset << 3).
- wr_len_qw = min(remaining, MAX_PAYLOAD_QW).
- wr_last = (remaining <= MAX_PAYLOAD_QW).
REQ-011 The outputs wr_addr, wr_len_qw and wr_last SHALL be held stable while wr_valid && !wr_ready.
REQ-012 On each wr_valid && wr_ready, offset SHALL advance by MAX_PAYLOAD_QW and remaining SHALL decrease by wr_len_qw; after the last chunk the block SHALL return to READY.
REQ-013 Because of REQ-012, every frame SHALL start on a 128-byte boundary and no chunk SHALL cross a 4 KiB boundary.
REQ-014 When offset == PAGE_QW after a last chunk, the block SHALL go to CLOSE instead of READY.
REQ-015 CLOSE SHALL last exactly one cycle: it pulses huge_page_free_<cur_page+1>, clears offset, toggles cur_page and enters WAIT_PAGE.
REQ-016 huge_page_free_1 and huge_page_free_2 SHALL never be asserted together, and each SHALL be asserted only in CLOSE.
REQ-017 page_base SHALL be sampled from huge_page_addr_<cur_page+1> on the WAIT_PAGE-to-READY transition; later changes to that input SHALL be ignored until the next page.
REQ-018 Status-drop handling:
- If the current page's status drops in READY, the block SHALL go to WAIT_PAGE without asserting free.
- If it drops in BURST, the block SHALL finish the frame first.

Reset
REQ-019 On reset, the block SHALL set:
- state = WAIT_PAGE, cur_page = 0, offset = 0, remaining = 0, page_base = 0.
- wr_valid, frame_req_ready, huge_page_free_1 and huge_page_free_2 all 0.
REQ-020 Reset asserted mid-BURST SHALL abandon the frame; no further commands SHALL be issued for it after reset is released.

Structure
REQ-021 A shared package SHALL hold the FSM state encodings, PAGE_QW, MAX_PAYLOAD_QW and the TLP format/type constants used by the RX and TX engines.
REQ-022 The design SHALL be a single module with no sub-modules; the chunk splitter remains inline.

Verification
REQ-023 Basic frame: status_1=1, addr_1=0x0000_0001_0000_0000, frame len 40 -> three commands:
- 0x1_0000_0000, len 16, last 0.
- 0x1_0000_0080, len 16, last 0.
- 0x1_0000_0100, len 8, last 1.
The next frame SHALL start at 0x1_0000_0180.
REQ-024 Backpressure: wr_ready held 0 for 5 cycles during the second chunk -> addr, len and last stable for the whole stall; no skipped or duplicated chunk.
REQ-025 Page full: offset = PAGE_QW-16, frame len 17 -> no acceptance, one-cycle huge_page_free_1 pulse, WAIT_PAGE. Then status_2=1 -> the frame is written at addr_2 + 0.
REQ-026 Exact fill: offset = PAGE_QW-16, frame len 16 -> one command, then huge_page_free_1 pulses the cycle after its acceptance.
REQ-027 Zero-length frame: frame len 0 -> accepted in one cycle, no wr_valid, offset unchanged.
REQ-028 Reset mid-burst: reset asserted for 2 cycles after the first chunk of a 40-qword frame -> all outputs 0, the block waits on status_1, offset 0.
